digit_phase_detector: RTL and testbench
=======================================

# digit_phase_detector

Carrier-phase detector for the QAM receive path, sitting directly downstream of the digital BPS filter and consuming its 1-bit `sgl_out`. It times each rising edge of the filtered carrier against a free-running local carrier counter. Once per symbol it emits the quantised phase of the last edge seen in that symbol window, with a valid strobe and a carrier-loss flag, for the symbol demapper.

## Interface
- `CARRIER_DIV`, 16: clock cycles per carrier period; power of two, ≥ 2^`PHASE_BITS`.
- `SYMBOL_CARRIERS`, 8: carrier periods per symbol window; ≥ 1.
- `PHASE_BITS`, 2: width of the quantised phase output.
- `clock`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `sgl_in`  in  1  filtered carrier from the BPS filter; synchronous to `clock`.
- `phase_out`  out  `PHASE_BITS`  quantised edge phase of the last completed symbol.
- `phase_valid`  out  1  one-cycle strobe; `phase_out`/`no_edge` updated this cycle.
- `no_edge`  out  1  last completed window contained no rising edge.

## Operation
- Input stage: `s0` registers `sgl_in` every clock.
- Filtered level `f`:
  - Without deglitch: `f` = `s0`.
  - With deglitch: see Configuration.
- `f_prev` registers `f`. Rising edge: `rise` = `f & ~f_prev`.
- Carrier counter `car_cnt`: width log2(`CARRIER_DIV`); counts 0..`CARRIER_DIV`-1, then wraps to 0.
- Symbol counter `sym_cnt`: 0..`SYMBOL_CARRIERS`-1; increments when `car_cnt` wraps, and wraps itself.
- Window end (`win_end`): the cycle where `car_cnt`=`CARRIER_DIV`-1 and `sym_cnt`=`SYMBOL_CARRIERS`-1.
- On `rise`:
  - `phase_reg` <= `car_cnt`.
  - `edge_seen` <= 1.
  - A later edge in the same window overwrites the earlier one; only the last edge counts.
- On `win_end`:
  - `phase_valid` <= 1.
  - `no_edge` <= ~(`edge_seen` | `rise`).
  - If an edge was seen: `phase_out` <= top `PHASE_BITS` bits of the captured phase (`phase_reg`, or `car_cnt` if `rise` is in this same cycle), i.e. floor(phase·2^`PHASE_BITS`/`CARRIER_DIV`).
  - If no edge was seen: `phase_out` holds its previous value.
  - `edge_seen` <= 0, even if `rise` coincides; a coincident edge belongs to the ending window.
- `phase_out` and `no_edge` hold between strobes.
- `phase_valid` is 0 on all other cycles.

## Timing
- Reset values: `phase_out`=0, `phase_valid`=0, `no_edge`=0, `car_cnt`=0, `sym_cnt`=0, `edge_seen`=0, `phase_reg`=0, all pipeline registers 0.
- Reset mid-window discards the partial window; no strobe is produced for it. Counting restarts at `car_cnt`=0 in the first cycle after release.
- Counting from release (cycle 0 has `car_cnt`=0), `phase_valid` is high in cycle N·`CARRIER_DIV`·`SYMBOL_CARRIERS` for N ≥ 1; with defaults these are cycles 128, 256, …
- Edge latency: if `sgl_in` is first high in a cycle with `car_cnt`=c, the captured phase is:
  - (c+1) mod `CARRIER_DIV` without deglitch;
  - (c+2) mod `CARRIER_DIV` with deglitch.
- A window owns every capture whose capture cycle lies within it.
- `sgl_in` high straight out of reset counts as an edge, because `f_prev` resets to 0.
- Output strobe: one cycle after `win_end`; no backpressure.

## Configuration
- `DIGIT_PHASE_DEGLITCH_EN` defined:
  - Adds `s1` and `s2` behind `s0`; `f` = registered majority(`s0`,`s1`,`s2`).
  - Single-cycle pulses or dropouts are rejected.
  - Edge latency increases by one cycle.
- Not defined:
  - `f` = `s0`; no majority logic or extra registers.
  - Every 0→1 transition of `s0` is an edge.

## Test plan
- Reset: assert `reset` asynchronously mid-window → all outputs 0 immediately; after release, first `phase_valid` at cycle 128 (defaults), not earlier.
- Aligned square wave, defaults, no deglitch: `sgl_in` high for `car_cnt` 7..14, low otherwise → capture 8; every strobe gives `phase_out`=2, `no_edge`=0.
- Phase sweep: shift the wave start so `sgl_in` rises at `car_cnt`=3, 7, 11, 15 → `phase_out`=1, 2, 3, 0 respectively (the last case checks wrap).
- Carrier loss: `sgl_in` held 0 for one full window → `no_edge`=1 and `phase_out` holds the prior value. The next window with edges → `no_edge`=0.
- Boundary edge: first high cycle at `car_cnt`=14 of the last carrier period → capture 15 in the `win_end` cycle → that strobe reports `phase_out`=3. The next window, with no further edges, reports `no_edge`=1.
- With `DIGIT_PHASE_DEGLITCH_EN`:
  - A 1-cycle high pulse on `sgl_in` in an otherwise idle window → `no_edge`=1.
  - The aligned square wave → capture 9, `phase_out`=2.

Source files
------------

// File: rtl/digit_phase_detector.sv
// rtl/digit_phase_detector.sv - times filtered-carrier rising edges against a local carrier counter, one phase per symbol
// Optional input deglitch majority filter enabled by DIGIT_PHASE_DEGLITCH_EN.
module digit_phase_detector #(
  parameter int CARRIER_DIV     = 16,
  parameter int SYMBOL_CARRIERS = 8,
  parameter int PHASE_BITS      = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sgl_in,
  output logic [PHASE_BITS-1:0] phase_out,
  output logic                  phase_valid,
  output logic                  no_edge
);

  localparam int CW = $clog2(CARRIER_DIV);
  localparam int SW = (SYMBOL_CARRIERS > 1) ? $clog2(SYMBOL_CARRIERS) : 1;

  logic          r_s0;
  logic          r_f_prev;
  logic [CW-1:0] r_car_cnt;
  logic [SW-1:0] r_sym_cnt;
  logic [CW-1:0] r_phase_reg;
  logic          r_edge_seen;

  logic          w_f;
  logic          w_rise;
  logic          w_car_wrap;
  logic          w_win_end;
  logic          w_any_edge;
  logic [CW-1:0] w_capture;

`ifdef DIGIT_PHASE_DEGLITCH_EN
  logic r_s1;
  logic r_s2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= r_s0;
      r_s2 <= r_s1;
    end
  end

  // Two of three registered samples must agree, so a lone 1-cycle pulse or dropout never moves f.
  assign w_f = (r_s0 & r_s1) | (r_s0 & r_s2) | (r_s1 & r_s2);
`else
  assign w_f = r_s0;
`endif

  assign w_rise     = w_f & ~r_f_prev;
  assign w_car_wrap = (r_car_cnt == CW'(CARRIER_DIV - 1));
  assign w_win_end  = w_car_wrap && (r_sym_cnt == SW'(SYMBOL_CARRIERS - 1));
  assign w_any_edge = r_edge_seen | w_rise;
  // An edge landing on the window-end cycle still belongs to the ending window.
  assign w_capture  = w_rise ? r_car_cnt : r_phase_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s0        <= 1'b0;
      r_f_prev    <= 1'b0;
      r_car_cnt   <= '0;
      r_sym_cnt   <= '0;
      r_phase_reg <= '0;
      r_edge_seen <= 1'b0;
      phase_out   <= '0;
      phase_valid <= 1'b0;
      no_edge     <= 1'b0;
    end else begin
      r_s0      <= sgl_in;
      r_f_prev  <= w_f;
      r_car_cnt <= r_car_cnt + 1'b1;
      if (w_car_wrap) begin
        r_sym_cnt <= (r_sym_cnt == SW'(SYMBOL_CARRIERS - 1)) ? '0 : r_sym_cnt + 1'b1;
      end
      if (w_rise) begin
        r_phase_reg <= r_car_cnt;
      end
      phase_valid <= w_win_end;
      if (w_win_end) begin
        no_edge     <= ~w_any_edge;
        r_edge_seen <= 1'b0;
        if (w_any_edge) begin
          phase_out <= w_capture[CW-1 -: PHASE_BITS];
        end
      end else if (w_rise) begin
        r_edge_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_digit_phase_detector.sv
// tb/tb_digit_phase_detector.sv - randomized bench for digit_phase_detector against a cycle-history reference model
// Build with DIGIT_PHASE_DEGLITCH_EN defined to check the deglitch variant.
module tb_digit_phase_detector;
  localparam int DIV  = 16;
  localparam int SC   = 8;
  localparam int PB   = 2;
  localparam int WIN  = DIV * SC;
  localparam int NLIT = 11;

  logic          clock = 1'b0;
  logic          reset;
  logic          sgl_in;
  logic [PB-1:0] phase_out;
  logic          phase_valid;
  logic          no_edge;

  digit_phase_detector #(.CARRIER_DIV(DIV), .SYMBOL_CARRIERS(SC), .PHASE_BITS(PB)) dut (
    .clock(clock), .reset(reset), .sgl_in(sgl_in),
    .phase_out(phase_out), .phase_valid(phase_valid), .no_edge(no_edge)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int t     = 0;
  int seg   = 0;
  bit run   = 0;

  int in_hist [0:8191];
  int mode_arr[0:63];
  int has_edge[0:63];
  int last_ph [0:63];
  int exp_ph, exp_ne;
  int lit_t[NLIT], lit_ph[NLIT], lit_ne[NLIT];
  int sweep_s[4] = '{3, 7, 11, 15};

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s t=%0d seg=%0d actual=%0d expected=%0d", nm, t, seg, act, expv);
    end
  endtask

  function automatic int inb(input int k);
    return (k < 0) ? 0 : in_hist[k];
  endfunction

  // Filtered level in cycle k, derived purely from the input history.
  function automatic int fval(input int k);
`ifdef DIGIT_PHASE_DEGLITCH_EN
    return ((inb(k-1) + inb(k-2) + inb(k-3)) >= 2) ? 1 : 0;
`else
    return inb(k-1);
`endif
  endfunction

  function automatic int gen(input int k, input int cur);
    int car, carr, m, s;
    car  = k % DIV;
    carr = (k / DIV) % SC;
    m    = mode_arr[k / WIN];
    case (m)
      0: return (car >= 7 && car <= 14) ? 1 : 0;
      1, 2, 3, 4: begin
        s = sweep_s[m-1];
        return (((car - s + DIV) % DIV) < 8) ? 1 : 0;
      end
      5: return 0;
      6: return (carr == SC-1 && car >= 14) ? 1 : 0;
      7: return 1;
      8: return int'($urandom % 2);
      9: return (($urandom % 20) == 0) ? 1 - cur : cur;
      10: return (carr == 3 && car == 5) ? 1 : 0;
      default: return ((car >= 7 && car <= 14) ? 1 : 0) ^ ((($urandom % 8) == 0) ? 1 : 0);
    endcase
  endfunction

  always @(negedge clock) begin
    int w;
    if (run) begin
      if (t == 0) begin
        for (int i = 0; i < 64; i++) begin
          has_edge[i] = 0;
          last_ph[i]  = 0;
        end
        exp_ph = 0;
        exp_ne = 0;
      end
      if (fval(t) == 1 && fval(t-1) == 0) begin
        has_edge[t / WIN] = 1;
        last_ph[t / WIN]  = t % DIV;
      end
      chk("phase_valid", int'(phase_valid), (t > 0 && t % WIN == 0) ? 1 : 0);
      if (t > 0 && t % WIN == 0) begin
        w = t / WIN - 1;
        if (has_edge[w] != 0) begin
          exp_ph = (last_ph[w] * (1 << PB)) / DIV;
          exp_ne = 0;
        end else begin
          exp_ne = 1;
        end
        if (seg == 0) begin
          for (int i = 0; i < NLIT; i++) begin
            if (lit_t[i] == t) begin
              chk("lit_phase", int'(phase_out), lit_ph[i]);
              chk("lit_no_edge", int'(no_edge), lit_ne[i]);
            end
          end
        end
      end
      chk("phase_out", int'(phase_out), exp_ph);
      chk("no_edge", int'(no_edge), exp_ne);
    end
  end

  task automatic drive_cycle();
    in_hist[t] = gen(t, int'(sgl_in));
    sgl_in = in_hist[t][0];
  endtask

  initial begin
    lit_t  = '{128, 256, 384, 512, 640, 768, 896, 1024, 1280, 1408, 1664};
    lit_ph = '{2,   2,   2,   2,   1,   2,   3,   0,    3,    3,    1};
    lit_ne = '{0,   0,   1,   0,   0,   0,   0,   0,    0,    1,    0};
`ifdef DIGIT_PHASE_DEGLITCH_EN
    lit_ph[8] = 2; lit_ne[8] = 1;
    lit_ph[9] = 0; lit_ne[9] = 0;
    lit_ph[10] = 0; lit_ne[10] = 1;
`endif
    mode_arr[0] = 0; mode_arr[1] = 0; mode_arr[2] = 5; mode_arr[3] = 0;
    mode_arr[4] = 1; mode_arr[5] = 2; mode_arr[6] = 3; mode_arr[7] = 4;
    mode_arr[8] = 0; mode_arr[9] = 6; mode_arr[10] = 7; mode_arr[11] = 5;
    mode_arr[12] = 10;
    for (int i = 13; i < 64; i++) mode_arr[i] = int'($urandom_range(0, 11));

    reset  = 1'b1;
    sgl_in = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    chk("reset_phase_out", int'(phase_out), 0);
    chk("reset_valid", int'(phase_valid), 0);
    chk("reset_no_edge", int'(no_edge), 0);
    reset = 1'b0;
    t = 0;
    drive_cycle();
    run = 1;
    while (t < 41 * WIN + 50) begin
      @(posedge clock);
      #1;
      t++;
      drive_cycle();
    end

    // Asynchronous reset in the middle of a window.
    #2;
    reset = 1'b1;
    run   = 0;
    #1;
    chk("async_phase_out", int'(phase_out), 0);
    chk("async_valid", int'(phase_valid), 0);
    chk("async_no_edge", int'(no_edge), 0);
    sgl_in = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    seg = 1;
    for (int i = 0; i < 64; i++) mode_arr[i] = int'($urandom_range(0, 11));
    mode_arr[0] = 7;
    reset = 1'b0;
    t = 0;
    drive_cycle();
    run = 1;
    while (t < 6 * WIN + 3) begin
      @(posedge clock);
      #1;
      t++;
      drive_cycle();
    end
    @(posedge clock);
    #1;
    run = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
